// File: rtl/nibble_pkg.sv
// Shared nibble definitions for the FIFO and the downstream 4-bit register stage.
package nibble_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Pointer/count width for a FIFO of the given depth: index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nibble_fifo_if.sv
// Valid/ready handshake bundle for nibble_fifo; watermark flags exist only when
// NIBBLE_FIFO_WATERMARK_EN is defined.
interface nibble_fifo_if
    import nibble_pkg::*;
#(
    parameter int unsigned DATA_W = NIBBLE_W,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = ptr_width(DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
`ifdef NIBBLE_FIFO_WATERMARK_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
`ifdef NIBBLE_FIFO_WATERMARK_EN
        output almost_full,
        output almost_empty,
`endif
        output count
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
`ifdef NIBBLE_FIFO_WATERMARK_EN
        input  almost_full,
        input  almost_empty,
`endif
        input  count
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: free-running counter modulo 2**PTR_W with increment enable.
module fifo_ptr #(
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/nibble_fifo.sv
// First-word-fall-through nibble FIFO feeding the downstream register's next_data.
// Define NIBBLE_FIFO_WATERMARK_EN to add registered almost_full/almost_empty flags.
module nibble_fifo
    import nibble_pkg::*;
#(
    parameter int unsigned DATA_W    = NIBBLE_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input logic        clk,
    input logic        reset,
    nibble_fifo_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = ptr_width(DEPTH);

    localparam bit PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                               (AF_THRESH <= DEPTH) && (AE_THRESH < DEPTH) &&
                               (DATA_W >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("nibble_fifo: DEPTH must be a power of two >= 2 and thresholds within range");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  count_q;
    logic [PTR_W-1:0]  count_d;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    // Flags come only from registered pointers, so in_ready never sees out_ready.
    assign push = bus.in_valid && !full && !reset;
    assign pop  = !empty && bus.out_ready && !reset;

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= bus.in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_idx];
    assign bus.count     = count_q;

`ifdef NIBBLE_FIFO_WATERMARK_EN
    logic almost_full_q;
    logic almost_empty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_d >= PTR_W'(AF_THRESH));
            almost_empty_q <= (count_d <= PTR_W'(AE_THRESH));
        end
    end

    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_nibble_fifo.sv
// Randomised and directed checks of nibble_fifo against a queue-based reference model.
module tb_nibble_fifo;
    import nibble_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nibble_fifo_if #(.DATA_W(NIBBLE_W), .DEPTH(DEPTH)) bus ();

    nibble_fifo #(
        .DATA_W    (NIBBLE_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_bad = 0;
    nibble_t model[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned sz;
        sz = model.size();
        check({tag, " count"}, 32'(bus.count), sz);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(sz != 0));
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(sz < DEPTH));
        check({tag, " out_data"}, 32'(bus.out_data), (sz != 0) ? 32'(model[0]) : 32'h0);
`ifdef NIBBLE_FIFO_WATERMARK_EN
        check({tag, " almost_full"}, 32'(bus.almost_full), 32'(sz >= AF));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(sz <= AE));
`endif
    endtask

    // Called at a negedge: drive, check pre-edge state, cross the edge, update model.
    task automatic cycle(input logic iv, input nibble_t d, input logic ordy, input string tag);
        bit do_push;
        bit do_pop;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        check_outputs(tag);
        do_push = iv && (model.size() < DEPTH);
        do_pop  = ordy && (model.size() != 0);
        @(posedge clk);
        if (do_pop) void'(model.pop_front());
        if (do_push) model.push_back(d);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        repeat (5) cycle(1'b0, 4'h0, 1'b0, "idle");

        // Three pushes with consumer stalled, then drain in order.
        cycle(1'b1, 4'h3, 1'b0, "push3");
        #1 check("fwft head", 32'(bus.out_data), 32'h3);
        cycle(1'b1, 4'hA, 1'b0, "pushA");
        cycle(1'b1, 4'hF, 1'b0, "pushF");
        #1 check("three queued", 32'(bus.count), 32'd3);
        repeat (4) cycle(1'b0, 4'h0, 1'b1, "drain3");
        #1 check("drained", 32'(bus.count), 32'd0);

        // Fill to DEPTH; ninth offer must be refused, even alongside a pop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, nibble_t'(i), 1'b0, "fill");
        #1 check("full in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 4'h8, 1'b0, "full hold");
        cycle(1'b1, 4'h8, 1'b1, "full pop");
        #1 check("ready after pop", 32'(bus.in_ready), 32'd1);
        check("count after pop", 32'(bus.count), DEPTH - 1);
        repeat (DEPTH + 1) cycle(1'b0, 4'h0, 1'b1, "drain full");

        // Steady streaming at occupancy 4 across pointer wraps.
        for (int i = 0; i < 4; i++) cycle(1'b1, nibble_t'($urandom), 1'b0, "prime");
        for (int i = 0; i < 20; i++) cycle(1'b1, nibble_t'($urandom), 1'b1, "stream");
        #1 check("stream count", 32'(bus.count), 32'd4);
        repeat (5) cycle(1'b0, 4'h0, 1'b1, "drain stream");

        // Reset asserted during an active push with five entries queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, nibble_t'(i + 9), 1'b0, "prefill");
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h5;
        reset        = 1'b1;
        model.delete();
        #1 check_outputs("in reset");
        @(posedge clk);
        @(negedge clk);
        check_outputs("reset held");
        reset = 1'b0;
        cycle(1'b1, 4'hC, 1'b0, "post reset push");
        #1 check("first after reset", 32'(bus.out_data), 32'hC);
        cycle(1'b0, 4'h0, 1'b1, "post reset pop");

`ifdef NIBBLE_FIFO_WATERMARK_EN
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, nibble_t'(i), 1'b0, "wm fill");
        #1 check("wm full af", 32'(bus.almost_full), 32'd1);
        check("wm full ae", 32'(bus.almost_empty), 32'd0);
        repeat (DEPTH + 1) cycle(1'b0, 4'h0, 1'b1, "wm drain");
`endif

        // Random traffic with varying densities.
        for (int blk = 0; blk < 8; blk++) begin
            int unsigned pv;
            int unsigned pr;
            pv = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 60; i++) begin
                cycle(logic'($urandom_range(99, 0) < pv), nibble_t'($urandom),
                      logic'($urandom_range(99, 0) < pr), "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
